mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: DATAWIDTH, 16, data and address bus width.
REQ-002 SHALL have parameter: STARVE_LIMIT, 3, consecutive CPU arbitration losses before CPU wins a tie (1-15).
REQ-003 SHALL have port: clk  input  1  system clock; sole clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports: cpu_req  input  1  CPU access request, level, held until cpu_done; cpu_we  input  1  1=write, 0=read.
REQ-006 SHALL have ports: cpu_addr  input  DATAWIDTH  CPU address; cpu_din  input  DATAWIDTH  CPU write data.
REQ-007 SHALL have ports: cpu_gnt  output  1  CPU owns SRAM; cpu_done  output  1  one-cycle completion pulse; cpu_dout  output  DATAWIDTH  CPU read data.
REQ-008 SHALL have ports: vga_req  input  1  display read request, level, held until vga_done; vga_addr  input  DATAWIDTH  display read address.
REQ-009 SHALL have ports: vga_done  output  1  one-cycle completion pulse; vga_dout  output  DATAWIDTH  display read data.
REQ-010 SHALL have ports: SRAM_CE, SRAM_OE, SRAM_WE  output  1 each  active-low SRAM strobes.
REQ-011 SHALL have ports: sram_addr  output  DATAWIDTH  SRAM address; sram_din  output  DATAWIDTH  SRAM write data; sram_dout  input  DATAWIDTH  SRAM read data.

Function
REQ-012 SHALL implement FSM IDLE -> SETUP -> STROBE -> IDLE; any other encoding -> IDLE.
REQ-013 SHALL arbitrate only in IDLE; no request -> stay IDLE; any request -> SETUP next cycle with winner latched as owner.
REQ-014 SHALL grant VGA when only vga_req high, CPU when only cpu_req high.
REQ-015 SHALL, both high, grant VGA unless wait counter == STARVE_LIMIT, then grant CPU.
REQ-016 SHALL keep a 4-bit wait counter: +1 per IDLE cycle with cpu_req high and VGA granted; cleared on CPU grant; saturates at STARVE_LIMIT.
REQ-017 SHALL latch owner address, write data and we on IDLE->SETUP; input changes after that ignored until access ends.
REQ-018 SHALL drive sram_addr/sram_din from latched values in SETUP and STROBE; hold last values otherwise.
REQ-019 SHALL, SETUP: SRAM_CE=0, SRAM_OE=0 for read, SRAM_WE=1.
REQ-020 SHALL, STROBE: SRAM_CE=0; read: SRAM_OE=0, SRAM_WE=1; write: SRAM_OE=1, SRAM_WE=0.
REQ-021 SHALL, IDLE: SRAM_CE=SRAM_OE=SRAM_WE=1.
REQ-022 SHALL register strobes (no combinational path from requests to strobes).
REQ-023 SHALL capture sram_dout at end of read STROBE into owner's dout register; other dout holds.
REQ-024 SHALL leave cpu_dout unchanged on CPU writes.
REQ-025 SHALL pulse owner's done for exactly one cycle, the cycle after STROBE (FSM in IDLE); dout valid same cycle.
REQ-026 SHALL give latency: req seen in IDLE cycle N -> done high in cycle N+3; back-to-back access every 3 cycles.
REQ-027 SHALL assert cpu_gnt in SETUP and STROBE of CPU accesses only.
REQ-028 SHALL complete a started access, with done pulse, even if the request drops mid-access.
REQ-029 SHALL treat requester holding req in the done cycle as a new request in that IDLE cycle.
REQ-030 SHALL never assert cpu_done and vga_done together.

Reset
REQ-031 SHALL, with rst high at a clock edge: FSM=IDLE, SRAM_CE/OE/WE=1, cpu_gnt=0, cpu_done=vga_done=0, cpu_dout=vga_dout=0, sram_addr=sram_din=0, wait counter=0.
REQ-032 SHALL, on reset mid-access, abort with no done pulse and no write strobe after the reset edge.
REQ-033 SHALL ignore requests while rst high; arbitration resumes the first cycle after rst falls.

Verification
REQ-034 CPU read only: cpu_addr=0x0040, sram_dout=0xBEEF in STROBE -> SRAM_OE low in SETUP and STROBE, cpu_done at N+3, cpu_dout=0xBEEF.
REQ-035 CPU write only: addr=0x0010, din=0x1234 -> SRAM_WE low one cycle (STROBE), sram_addr=0x0010, sram_din=0x1234, SRAM_OE high, cpu_done at N+3.
REQ-036 Both held continuously, STARVE_LIMIT=3 -> grant order VGA,VGA,VGA,CPU repeating; counter back to 0 after CPU grant.
REQ-037 Both held continuously, STARVE_LIMIT=3 -> done pulses 3 cycles apart, never both high.
REQ-038 rst high during CPU write STROBE -> next cycle all strobes high, no cpu_done, cpu_dout=0.
REQ-039 cpu_addr changed 0x0040->0x0041 during SETUP -> sram_addr stays 0x0040 through STROBE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/VGA arbiter sharing one asynchronous SRAM
//
// Three-cycle access: IDLE (arbitrate) -> SETUP (address out) -> STROBE
// (read/write strobe) -> IDLE (done pulse, read data valid). VGA normally
// wins ties; a 4-bit wait counter lets the CPU through after STARVE_LIMIT
// consecutive losses. Every SRAM-facing output is a flop.
module mem_arbiter #(
  parameter int DATAWIDTH    = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  // CPU port
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [DATAWIDTH-1:0] cpu_addr,
  input  logic [DATAWIDTH-1:0] cpu_din,
  output logic                 cpu_gnt,
  output logic                 cpu_done,
  output logic [DATAWIDTH-1:0] cpu_dout,
  // display port (read only)
  input  logic                 vga_req,
  input  logic [DATAWIDTH-1:0] vga_addr,
  output logic                 vga_done,
  output logic [DATAWIDTH-1:0] vga_dout,
  // SRAM
  output logic                 SRAM_CE,
  output logic                 SRAM_OE,
  output logic                 SRAM_WE,
  output logic [DATAWIDTH-1:0] sram_addr,
  output logic [DATAWIDTH-1:0] sram_din,
  input  logic [DATAWIDTH-1:0] sram_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t     state;
  logic       owner_cpu;
  logic       owner_we;
  logic [3:0] wait_cnt;
  logic       cpu_wins;

  // Winner of the current IDLE cycle: VGA by default, CPU when alone or starved
  always_comb begin
    cpu_wins = cpu_req && (!vga_req || (wait_cnt == LIMIT));
  end

  // Access sequencer with registered SRAM strobes, grant, done and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_cpu <= 1'b0;
      owner_we  <= 1'b0;
      wait_cnt  <= 4'd0;
      SRAM_CE   <= 1'b1;
      SRAM_OE   <= 1'b1;
      SRAM_WE   <= 1'b1;
      cpu_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      vga_done  <= 1'b0;
      cpu_dout  <= '0;
      vga_dout  <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      cpu_done <= 1'b0;
      vga_done <= 1'b0;
      case (state)
        IDLE: begin
          SRAM_CE <= 1'b1;
          SRAM_OE <= 1'b1;
          SRAM_WE <= 1'b1;
          cpu_gnt <= 1'b0;
          if (cpu_req || vga_req) begin
            state     <= SETUP;
            owner_cpu <= cpu_wins;
            owner_we  <= cpu_wins && cpu_we;
            // Address/data are captured here; later input changes are ignored
            sram_addr <= cpu_wins ? cpu_addr : vga_addr;
            if (cpu_wins) begin
              sram_din <= cpu_din;
            end
            SRAM_CE <= 1'b0;
            SRAM_OE <= cpu_wins && cpu_we;
            cpu_gnt <= cpu_wins;
            if (cpu_wins) begin
              wait_cnt <= 4'd0;
            end else if (cpu_req && (wait_cnt != LIMIT)) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end
        SETUP: begin
          state   <= STROBE;
          SRAM_CE <= 1'b0;
          SRAM_OE <= owner_we;
          SRAM_WE <= ~owner_we;
        end
        STROBE: begin
          state   <= IDLE;
          SRAM_CE <= 1'b1;
          SRAM_OE <= 1'b1;
          SRAM_WE <= 1'b1;
          cpu_gnt <= 1'b0;
          if (!owner_we) begin
            if (owner_cpu) begin
              cpu_dout <= sram_dout;
            end else begin
              vga_dout <= sram_dout;
            end
          end
          if (owner_cpu) begin
            cpu_done <= 1'b1;
          end else begin
            vga_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          SRAM_CE <= 1'b1;
          SRAM_OE <= 1'b1;
          SRAM_WE <= 1'b1;
          cpu_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [DW-1:0] cpu_addr, cpu_din;
  logic          cpu_gnt, cpu_done;
  logic [DW-1:0] cpu_dout;
  logic          vga_req;
  logic [DW-1:0] vga_addr;
  logic          vga_done;
  logic [DW-1:0] vga_dout;
  logic          SRAM_CE, SRAM_OE, SRAM_WE;
  logic [DW-1:0] sram_addr, sram_din, sram_dout;

  mem_arbiter #(.DATAWIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_dout(cpu_dout),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_done(vga_done), .vga_dout(vga_dout),
    .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE), .SRAM_WE(SRAM_WE),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // 16-word SRAM behavioural model, indexed by the low address bits
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hBEEF ^ 16'(i);
    end else if (!SRAM_CE && !SRAM_WE) begin
      mem[sram_addr[3:0]] <= sram_din;
    end
  end
  assign sram_dout = (!SRAM_CE && !SRAM_OE) ? mem[sram_addr[3:0]] : 16'hDEAD;

  // Scoreboard and transaction-level reference model
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cnt;
  bit acc_valid, acc_cpu, acc_we;
  int acc_g;
  logic [DW-1:0] acc_addr, acc_din;
  logic [DW-1:0] exp_cpu_dout, exp_vga_dout, exp_sram_addr;
  logic [DW-1:0] ref_mem [16];
  bit cpu_fin, vga_fin;
  bit grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Apply the arbitration rules to the inputs presented for this cycle's edge
  task automatic model_arb();
    bit win;
    if (rst) begin
      acc_valid = 0;
      cnt = 0;
      exp_cpu_dout = '0;
      exp_vga_dout = '0;
      exp_sram_addr = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 16'hBEEF ^ 16'(i);
      return;
    end
    if (!acc_valid && (cpu_req || vga_req)) begin
      win = cpu_req && (!vga_req || cnt == LIMIT);
      if (win) cnt = 0;
      else if (cpu_req && cnt < LIMIT) cnt++;
      acc_valid = 1;
      acc_g = cyc;
      acc_cpu = win;
      acc_we = win && cpu_we;
      acc_addr = win ? cpu_addr : vga_addr;
      acc_din = cpu_din;
      exp_sram_addr = acc_addr;
      grant_log.push_back(win);
    end
  endtask

  // Compare all outputs of the current cycle against the access timeline
  task automatic check();
    bit in_setup, in_strobe, done_now, active;
    in_setup  = acc_valid && (cyc == acc_g + 1);
    in_strobe = acc_valid && (cyc == acc_g + 2);
    done_now  = acc_valid && (cyc == acc_g + 3);
    active    = in_setup || in_strobe;
    cpu_fin = 0;
    vga_fin = 0;
    chk("sram_ce", SRAM_CE, !active);
    chk("sram_oe", SRAM_OE, !(active && !acc_we));
    chk("sram_we", SRAM_WE, !(in_strobe && acc_we));
    chk("cpu_gnt", cpu_gnt, active && acc_cpu);
    chk("sram_addr", sram_addr, exp_sram_addr);
    if (in_strobe && acc_we) chk("sram_din", sram_din, acc_din);
    if (done_now) begin
      if (acc_we) ref_mem[acc_addr[3:0]] = acc_din;
      else if (acc_cpu) exp_cpu_dout = ref_mem[acc_addr[3:0]];
      else exp_vga_dout = ref_mem[acc_addr[3:0]];
    end
    chk("cpu_done", cpu_done, done_now && acc_cpu);
    chk("vga_done", vga_done, done_now && !acc_cpu);
    chk("done_exclusive", cpu_done && vga_done, 1'b0);
    chk("cpu_dout", cpu_dout, exp_cpu_dout);
    chk("vga_dout", vga_dout, exp_vga_dout);
    if (done_now) begin
      acc_valid = 0;
      if (acc_cpu) cpu_fin = 1;
      else vga_fin = 1;
    end
  endtask

  task automatic step();
    model_arb();
    @(negedge clk);
    cyc++;
    check();
  endtask

  task automatic new_cpu_txn();
    cpu_we   = 1'($urandom);
    cpu_addr = 16'($urandom);
    cpu_din  = 16'($urandom);
  endtask

  initial begin
    int start;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    vga_req = 0; vga_addr = '0;
    @(negedge clk);
    // Reset state; requests while in reset are ignored
    vga_req = 1;
    step();
    chk("rst_ce", SRAM_CE, 1'b1);
    chk("rst_dout", cpu_dout, 16'h0000);
    vga_req = 0;
    rst = 1'b0;

    // CPU read at 0x0040; address change during SETUP must not leak out
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    step();
    chk("rd_setup_oe", SRAM_OE, 1'b0);
    cpu_addr = 16'h0041;
    step();
    chk("rd_strobe_addr", sram_addr, 16'h0040);
    chk("rd_strobe_oe", SRAM_OE, 1'b0);
    step();
    chk("rd_done", cpu_done, 1'b1);
    chk("rd_data", cpu_dout, 16'hBEEF);
    cpu_req = 0;
    step();

    // CPU write 0x1234 to 0x0010
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_din = 16'h1234;
    step();
    step();
    chk("wr_we", SRAM_WE, 1'b0);
    chk("wr_oe", SRAM_OE, 1'b1);
    chk("wr_addr", sram_addr, 16'h0010);
    chk("wr_din", sram_din, 16'h1234);
    step();
    chk("wr_done", cpu_done, 1'b1);
    chk("wr_dout_hold", cpu_dout, 16'hBEEF);
    cpu_req = 0;
    step();

    // Both requesters held: VGA,VGA,VGA,CPU repeating
    start = grant_log.size();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    vga_req = 1; vga_addr = 16'h0007;
    for (int i = 0; i < 36; i++) step();
    cpu_req = 0; vga_req = 0;
    step();
    chk("starve_count", grant_log.size() - start, 12);
    for (int k = 0; k < 12; k++) begin
      if (start + k < grant_log.size())
        chk("starve_order", grant_log[start + k], (k % 4) == 3);
    end

    // Reset during a CPU write strobe aborts the access
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0005; cpu_din = 16'hAAAA;
    step();
    step();
    chk("abort_pre_we", SRAM_WE, 1'b0);
    rst = 1'b1;
    cpu_req = 0;
    step();
    chk("abort_we", SRAM_WE, 1'b1);
    chk("abort_ce", SRAM_CE, 1'b1);
    chk("abort_oe", SRAM_OE, 1'b1);
    chk("abort_done", cpu_done, 1'b0);
    chk("abort_dout", cpu_dout, 16'h0000);
    rst = 1'b0;
    step();
    chk("abort_no_done", cpu_done, 1'b0);

    // Randomized requesters, with mid-access drops and input scrambling
    for (int n = 0; n < 900; n++) begin
      if (acc_valid && acc_cpu) begin
        if ($urandom_range(0, 5) == 0) cpu_req = 0;
        new_cpu_txn();
      end else if (cpu_fin && cpu_req) begin
        if ($urandom_range(0, 1) == 1) new_cpu_txn();
        else cpu_req = 0;
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1;
        new_cpu_txn();
      end
      if (acc_valid && !acc_cpu) begin
        if ($urandom_range(0, 5) == 0) vga_req = 0;
        vga_addr = 16'($urandom);
      end else if (vga_fin && vga_req) begin
        if ($urandom_range(0, 3) != 0) vga_addr = 16'($urandom);
        else vga_req = 0;
      end else if (!vga_req && $urandom_range(0, 1) == 0) begin
        vga_req = 1;
        vga_addr = 16'($urandom);
      end
      step();
    end

    cpu_req = 0; vga_req = 0;
    for (int i = 0; i < 6; i++) step();
    chk("drain_idle", acc_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
